// File: rtl/encoder_ctrl_pkg.sv
// Shared command and FSM encodings for the encoder controller and the block that issues its commands.
package encoder_ctrl_pkg;

    localparam logic [1:0] OP_HEADER = 2'b00;
    localparam logic [1:0] OP_STATUS = 2'b01;
    localparam logic [1:0] OP_TAG    = 2'b10;
    localparam logic [1:0] OP_BUNDLE = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/encoder_ctrl.sv
// Encoder controller: accepts one command at a time, steers the datapath selects and
// sequences output words, while a bundle buffer fills independently in the background.
module encoder_ctrl
    import encoder_ctrl_pkg::*;
#(
    parameter int BUS_SIZE  = 32,
    parameter int n         = 128,
    parameter int BLCK_SIZE = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       bundle_valid,
    output logic       bundle_ready,
    input  logic       data_out_ready,
    input  logic       early_invalid,
    output logic       ctrl_mux_sel_status,
    output logic       ctrl_mux_sel_seginfo,
    output logic       ctrl_mux_sel_bypass_bundle,
    output logic       enable_4L,
    output logic       enable_4H,
    output logic       unlock_validity,
    output logic [$clog2(BLCK_SIZE/BUS_SIZE)-1:0] mux_out_ctrl,
    output logic       done,
    output logic [0:0] dbg_state,
    output logic       dbg_hi_full
);

    localparam int         MUX_W     = $clog2(BLCK_SIZE / BUS_SIZE);
    localparam logic [1:0] LAST_WORD = 2'(n / BUS_SIZE - 1);

    // Handshake rule for both channels: a transfer happens in a cycle where valid and
    // ready are both high; ready never waits on valid, valid must hold until accepted.
    logic [0:0] state;
    logic [1:0] cnt;
    logic [1:0] lst;
    logic       hi_full;
    logic       accept;
    logic       bundle_accept;
    logic       emitting;

    assign emitting      = (state == ST_EMIT);
    assign cmd_ready     = rst & ~emitting & ((cmd_op != OP_BUNDLE) | hi_full);
    assign accept        = cmd_valid & cmd_ready;
    assign bundle_accept = accept & (cmd_op == OP_BUNDLE);

    // A bundle command frees the high half on the same edge it is moved low.
    assign bundle_ready  = rst & (~hi_full | bundle_accept);
    assign enable_4H     = bundle_valid & bundle_ready;

    assign unlock_validity = emitting;
    assign mux_out_ctrl    = emitting ? MUX_W'(cnt) : '0;
    assign done            = emitting & (early_invalid | (data_out_ready & (cnt == lst)));
    assign dbg_state       = state;
    assign dbg_hi_full     = hi_full;

    always_comb begin
        enable_4L                  = 1'b0;
        ctrl_mux_sel_status        = 1'b0;
        ctrl_mux_sel_seginfo       = 1'b0;
        ctrl_mux_sel_bypass_bundle = 1'b0;
        if (accept) begin
            enable_4L = 1'b1;
            case (cmd_op)
                OP_HEADER: ctrl_mux_sel_seginfo = 1'b1;
                OP_STATUS: begin
                    ctrl_mux_sel_seginfo = 1'b1;
                    ctrl_mux_sel_status  = 1'b1;
                end
                OP_BUNDLE: ctrl_mux_sel_bypass_bundle = 1'b1;
                default:   ctrl_mux_sel_seginfo = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_full <= 1'b0;
        end else if (enable_4H) begin
            hi_full <= 1'b1;
        end else if (bundle_accept) begin
            hi_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
            lst   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EMIT;
                        cnt   <= 2'd0;
                        lst   <= ((cmd_op == OP_HEADER) || (cmd_op == OP_STATUS)) ? 2'd0 : LAST_WORD;
                    end
                end
                ST_EMIT: begin
                    if (early_invalid) begin
                        state <= ST_IDLE;
                    end else if (data_out_ready) begin
                        if (cnt == lst) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_ctrl.sv
// Bench for encoder_ctrl: directed scenarios followed by random traffic against a word-queue model.
module tb_encoder_ctrl;
    import encoder_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       bundle_valid;
    logic       bundle_ready;
    logic       data_out_ready;
    logic       early_invalid;
    logic       ctrl_mux_sel_status;
    logic       ctrl_mux_sel_seginfo;
    logic       ctrl_mux_sel_bypass_bundle;
    logic       enable_4L;
    logic       enable_4H;
    logic       unlock_validity;
    logic [2:0] mux_out_ctrl;
    logic       done;
    logic [0:0] dbg_state;
    logic       dbg_hi_full;

    int total = 0;
    int bad   = 0;

    encoder_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
        .data_out_ready(data_out_ready), .early_invalid(early_invalid),
        .ctrl_mux_sel_status(ctrl_mux_sel_status),
        .ctrl_mux_sel_seginfo(ctrl_mux_sel_seginfo),
        .ctrl_mux_sel_bypass_bundle(ctrl_mux_sel_bypass_bundle),
        .enable_4L(enable_4L), .enable_4H(enable_4H),
        .unlock_validity(unlock_validity), .mux_out_ctrl(mux_out_ctrl),
        .done(done), .dbg_state(dbg_state), .dbg_hi_full(dbg_hi_full)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // drivers
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid      = 1'b0;
        cmd_op         = OP_HEADER;
        bundle_valid   = 1'b0;
        data_out_ready = 1'b1;
        early_invalid  = 1'b0;
    endtask

    function automatic logic [11:0] obs_vec();
        return {cmd_ready, bundle_ready, ctrl_mux_sel_status, ctrl_mux_sel_seginfo,
                ctrl_mux_sel_bypass_bundle, enable_4L, enable_4H, unlock_validity,
                mux_out_ctrl, done};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_HEADER; bundle_valid = 1'b1;
        data_out_ready = 1'b1; early_invalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (obs_vec() !== 12'h000) begin bad++; $display("FAIL reset_outputs got=%h exp=000", obs_vec()); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        total++; if (dbg_hi_full !== 1'b0) begin bad++; $display("FAIL reset_hi_full got=%0b exp=0", dbg_hi_full); end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL release_cmd_ready got=%0b exp=1", cmd_ready); end
        total++; if (bundle_ready !== 1'b1) begin bad++; $display("FAIL release_bundle_ready got=%0b exp=1", bundle_ready); end
    endtask

    task automatic test_header();
        next_cycle();
        cmd_valid = 1'b1; cmd_op = OP_HEADER; data_out_ready = 1'b1;
        @(negedge clk);
        total++; if (enable_4L !== 1'b1) begin bad++; $display("FAIL hdr_en4l got=%0b exp=1", enable_4L); end
        total++; if ({ctrl_mux_sel_seginfo, ctrl_mux_sel_status, ctrl_mux_sel_bypass_bundle} !== 3'b100)
            begin bad++; $display("FAIL hdr_sel got=%b exp=100", {ctrl_mux_sel_seginfo, ctrl_mux_sel_status, ctrl_mux_sel_bypass_bundle}); end
        next_cycle();
        cmd_valid = 1'b0;
        @(negedge clk);
        total++; if ({unlock_validity, mux_out_ctrl, done} !== 5'b1_000_1)
            begin bad++; $display("FAIL hdr_word0 got=%b exp=10001", {unlock_validity, mux_out_ctrl, done}); end
        next_cycle();
        @(negedge clk);
        total++; if ({dbg_state, unlock_validity, done} !== 3'b000)
            begin bad++; $display("FAIL hdr_idle got=%b exp=000", {dbg_state, unlock_validity, done}); end
    endtask

    task automatic test_status();
        next_cycle();
        cmd_valid = 1'b1; cmd_op = OP_STATUS; data_out_ready = 1'b1;
        @(negedge clk);
        total++; if ({enable_4L, ctrl_mux_sel_seginfo, ctrl_mux_sel_status, ctrl_mux_sel_bypass_bundle} !== 4'b1110)
            begin bad++; $display("FAIL status_sel got=%b exp=1110", {enable_4L, ctrl_mux_sel_seginfo, ctrl_mux_sel_status, ctrl_mux_sel_bypass_bundle}); end
        next_cycle();
        cmd_valid = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL status_done got=%0b exp=1", done); end
        next_cycle();
    endtask

    task automatic test_tag_stall();
        logic [2:0] exp_mux [5] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
        logic       rdy     [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        next_cycle();
        cmd_valid = 1'b1; cmd_op = OP_TAG; data_out_ready = 1'b1;
        @(negedge clk);
        total++; if ({enable_4L, ctrl_mux_sel_seginfo, ctrl_mux_sel_bypass_bundle} !== 3'b100)
            begin bad++; $display("FAIL tag_accept got=%b exp=100", {enable_4L, ctrl_mux_sel_seginfo, ctrl_mux_sel_bypass_bundle}); end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            cmd_valid = 1'b0;
            data_out_ready = rdy[k];
            @(negedge clk);
            total++; if (mux_out_ctrl !== exp_mux[k]) begin bad++; $display("FAIL tag_mux k=%0d got=%0d exp=%0d", k, mux_out_ctrl, exp_mux[k]); end
            total++; if (done !== (k == 4)) begin bad++; $display("FAIL tag_done k=%0d got=%0b exp=%0b", k, done, (k == 4)); end
        end
        next_cycle();
        data_out_ready = 1'b1;
        @(negedge clk);
        total++; if (unlock_validity !== 1'b0) begin bad++; $display("FAIL tag_idle got=%0b exp=0", unlock_validity); end
    endtask

    task automatic test_bundle_stall();
        next_cycle();
        cmd_valid = 1'b1; cmd_op = OP_BUNDLE; bundle_valid = 1'b0;
        @(negedge clk);
        total++; if ({cmd_ready, bundle_ready, enable_4L} !== 3'b010)
            begin bad++; $display("FAIL bstall_wait got=%b exp=010", {cmd_ready, bundle_ready, enable_4L}); end
        next_cycle();
        bundle_valid = 1'b1;
        @(negedge clk);
        total++; if ({enable_4H, cmd_ready} !== 2'b10)
            begin bad++; $display("FAIL bstall_load got=%b exp=10", {enable_4H, cmd_ready}); end
        next_cycle();
        bundle_valid = 1'b0;
        @(negedge clk);
        total++; if ({cmd_ready, ctrl_mux_sel_bypass_bundle, enable_4L} !== 3'b111)
            begin bad++; $display("FAIL bstall_accept got=%b exp=111", {cmd_ready, ctrl_mux_sel_bypass_bundle, enable_4L}); end
        next_cycle();
        cmd_valid = 1'b0; early_invalid = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bstall_abort_done got=%0b exp=1", done); end
        next_cycle();
        early_invalid = 1'b0;
        @(negedge clk);
        total++; if ({dbg_hi_full, dbg_state} !== 2'b00)
            begin bad++; $display("FAIL bstall_cleared got=%b exp=00", {dbg_hi_full, dbg_state}); end
    endtask

    task automatic test_early_invalid();
        next_cycle();
        bundle_valid = 1'b1;
        next_cycle();
        bundle_valid = 1'b0; cmd_valid = 1'b1; cmd_op = OP_BUNDLE; data_out_ready = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL einv_accept got=%0b exp=1", cmd_ready); end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            cmd_valid = 1'b0;
            early_invalid = (k == 2);
            @(negedge clk);
            total++; if (mux_out_ctrl !== 3'(k)) begin bad++; $display("FAIL einv_mux k=%0d got=%0d exp=%0d", k, mux_out_ctrl, k); end
            total++; if (done !== (k == 2)) begin bad++; $display("FAIL einv_done k=%0d got=%0b exp=%0b", k, done, (k == 2)); end
        end
        next_cycle();
        early_invalid = 1'b0;
        @(negedge clk);
        total++; if ({dbg_state, unlock_validity} !== 2'b00)
            begin bad++; $display("FAIL einv_idle got=%b exp=00", {dbg_state, unlock_validity}); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        bundle_valid = 1'b1;
        next_cycle();
        cmd_valid = 1'b1; cmd_op = OP_BUNDLE; bundle_valid = 1'b1; data_out_ready = 1'b1;
        @(negedge clk);
        total++; if ({enable_4L, enable_4H, ctrl_mux_sel_bypass_bundle, bundle_ready} !== 4'b1111)
            begin bad++; $display("FAIL b2b_swap got=%b exp=1111", {enable_4L, enable_4H, ctrl_mux_sel_bypass_bundle, bundle_ready}); end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            bundle_valid = 1'b0;
            @(negedge clk);
            total++; if ({cmd_ready, mux_out_ctrl, done} !== {1'b0, 3'(k), k == 3})
                begin bad++; $display("FAIL b2b_word k=%0d got=%b exp=%b", k, {cmd_ready, mux_out_ctrl, done}, {1'b0, 3'(k), k == 3}); end
            if (k == 0) begin
                total++; if (dbg_hi_full !== 1'b1) begin bad++; $display("FAIL b2b_hi_full got=%0b exp=1", dbg_hi_full); end
            end
        end
        next_cycle();
        @(negedge clk);
        total++; if ({cmd_ready, enable_4L, ctrl_mux_sel_bypass_bundle} !== 3'b111)
            begin bad++; $display("FAIL b2b_second got=%b exp=111", {cmd_ready, enable_4L, ctrl_mux_sel_bypass_bundle}); end
        next_cycle();
        cmd_valid = 1'b0; early_invalid = 1'b1;
        next_cycle();
        early_invalid = 1'b0;
    endtask

    task automatic test_reset_mid_emit();
        next_cycle();
        bundle_valid = 1'b1;
        next_cycle();
        bundle_valid = 1'b0; cmd_valid = 1'b1; cmd_op = OP_TAG; data_out_ready = 1'b1;
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        next_cycle();
        #2;
        total++; if (mux_out_ctrl !== 3'd2) begin bad++; $display("FAIL rmid_pre got=%0d exp=2", mux_out_ctrl); end
        rst = 1'b0;
        #1;
        total++; if (obs_vec() !== 12'h000) begin bad++; $display("FAIL rmid_outputs got=%h exp=000", obs_vec()); end
        total++; if (dbg_hi_full !== 1'b0) begin bad++; $display("FAIL rmid_hi_full got=%0b exp=0", dbg_hi_full); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_no_done got=%0b exp=0", done); end
        next_cycle();
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_HEADER;
        @(negedge clk);
        total++; if ({cmd_ready, enable_4L} !== 2'b11)
            begin bad++; $display("FAIL rmid_first_accept got=%b exp=11", {cmd_ready, enable_4L}); end
        next_cycle();
        cmd_valid = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_hdr_done got=%0b exp=1", done); end
        next_cycle();
    endtask

    // scoreboard: the words still owed by the current command, in order
    logic [2:0] exp_q[$];
    bit         m_hi;

    task automatic test_random();
        bit         busy, acc, exp_4h, exp_br, exp_cr, exp_done;
        logic [11:0] exp_v;
        rst = 1'b0;
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        exp_q.delete();
        m_hi = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            cmd_valid      = ($urandom_range(0, 1) == 1);
            cmd_op         = 2'($urandom_range(0, 3));
            bundle_valid   = ($urandom_range(0, 9) < 3);
            data_out_ready = ($urandom_range(0, 9) < 7);
            early_invalid  = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            busy     = (exp_q.size() != 0);
            exp_cr   = !busy && (cmd_op != OP_BUNDLE || m_hi);
            acc      = cmd_valid && exp_cr;
            exp_br   = !m_hi || (acc && cmd_op == OP_BUNDLE);
            exp_4h   = bundle_valid && exp_br;
            exp_done = busy && (early_invalid || (data_out_ready && exp_q.size() == 1));
            exp_v = {exp_cr, exp_br,
                     acc && cmd_op == OP_STATUS,
                     acc && (cmd_op == OP_HEADER || cmd_op == OP_STATUS),
                     acc && cmd_op == OP_BUNDLE,
                     acc, exp_4h, busy,
                     busy ? exp_q[0] : 3'd0,
                     exp_done};
            total++; if (obs_vec() !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_v); end
            if (busy) begin
                if (early_invalid) exp_q.delete();
                else if (data_out_ready) void'(exp_q.pop_front());
            end
            if (acc) begin
                if (cmd_op == OP_HEADER || cmd_op == OP_STATUS) exp_q.push_back(3'd0);
                else for (int w = 0; w < 4; w++) exp_q.push_back(3'(w));
            end
            if (exp_4h) m_hi = 1'b1;
            else if (acc && cmd_op == OP_BUNDLE) m_hi = 1'b0;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_header();
        test_status();
        test_tag_stall();
        test_bundle_stall();
        test_early_invalid();
        test_back_to_back();
        test_reset_mid_emit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
